// File: rtl/isqrt_share_arbiter.sv
// Round-robin sharing of one pipelined isqrt between N_REQ requesters.
// A {vld, tag} pipeline runs alongside the isqrt and steers each result home.
module isqrt_share_arbiter #(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned ISQRT_LATENCY = 16,
    localparam int unsigned TAG_W        = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_vld,
    input  logic [N_REQ*32-1:0]  req_x,
    output logic [N_REQ-1:0]     req_rdy,
    output logic                 sq_x_vld,
    output logic [31:0]          sq_x,
    input  logic                 sq_y_vld,
    input  logic [15:0]          sq_y,
    output logic [N_REQ-1:0]     rsp_vld,
    output logic [15:0]          rsp_y,
    output logic                 busy,
    output logic                 err
);

    logic [TAG_W-1:0] ptr;
    logic [TAG_W-1:0] gidx;
    logic [N_REQ-1:0] grant;
    logic             grant_any;
    logic [TAG_W-1:0] tag0;
    logic             stage_vld [ISQRT_LATENCY];
    logic [TAG_W-1:0] stage_tag [ISQRT_LATENCY];
    logic             tag_out_vld;
    logic [TAG_W-1:0] tag_out;
    logic             busy_next;

    // First pending requester in scan order ptr, ptr+1, ... wins.
    always_comb begin
        int unsigned      idx;
        logic [TAG_W-1:0] cand;
        idx       = 0;
        cand      = '0;
        grant     = '0;
        gidx      = '0;
        grant_any = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx  = (32'(ptr) + k) % N_REQ;
            cand = TAG_W'(idx);
            if (!grant_any && req_vld[cand]) begin
                grant_any = 1'b1;
                gidx      = cand;
            end
        end
        if (grant_any) begin
            grant[gidx] = 1'b1;
        end
    end

    assign req_rdy = rst ? '0 : grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            sq_x_vld <= 1'b0;
            sq_x     <= '0;
            tag0     <= '0;
        end else begin
            sq_x_vld <= grant_any;
            if (grant_any) begin
                sq_x <= req_x[32*gidx +: 32];
                tag0 <= gidx;
                ptr  <= (gidx == TAG_W'(N_REQ - 1)) ? '0 : gidx + TAG_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < ISQRT_LATENCY; k++) begin
                stage_vld[k] <= 1'b0;
            end
        end else begin
            stage_vld[0] <= sq_x_vld;
            for (int unsigned k = 1; k < ISQRT_LATENCY; k++) begin
                stage_vld[k] <= stage_vld[k-1];
            end
        end
    end

    // Tag payload only moves behind a valid entry, so idle stages do not toggle.
    always_ff @(posedge clk) begin
        if (sq_x_vld) begin
            stage_tag[0] <= tag0;
        end
        for (int unsigned k = 1; k < ISQRT_LATENCY; k++) begin
            if (stage_vld[k-1]) begin
                stage_tag[k] <= stage_tag[k-1];
            end
        end
    end

    assign tag_out_vld = stage_vld[ISQRT_LATENCY-1];
    assign tag_out     = stage_tag[ISQRT_LATENCY-1];

    // busy reflects what the pipeline will hold after this edge.
    always_comb begin
        busy_next = grant_any | sq_x_vld;
        for (int unsigned k = 0; k + 1 < ISQRT_LATENCY; k++) begin
            busy_next = busy_next | stage_vld[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            err  <= 1'b0;
        end else begin
            busy <= busy_next;
            if (sq_y_vld != tag_out_vld) begin
                err <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_rsp
        assign rsp_vld[i] = sq_y_vld & tag_out_vld & (tag_out == TAG_W'(i));
    end

    assign rsp_y = sq_y;

endmodule

// File: tb/tb_isqrt_share_arbiter.sv
// Directed bench for isqrt_share_arbiter with a behavioural 16-cycle isqrt
// and a queue scoreboard of expected responses.
module tb_isqrt_share_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned LAT = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_vld;
    logic [N*32-1:0] req_x;
    logic [N-1:0]    req_rdy;
    logic            sq_x_vld;
    logic [31:0]     sq_x;
    logic            sq_y_vld;
    logic [15:0]     sq_y;
    logic [N-1:0]    rsp_vld;
    logic [15:0]     rsp_y;
    logic            busy;
    logic            err;
    logic            spur;

    int unsigned n_vec  = 0;
    int unsigned n_bad  = 0;
    int unsigned cycle  = 0;

    typedef struct {
        int unsigned idx;
        logic [15:0] y;
        int unsigned due;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_y [N];

    isqrt_share_arbiter #(.N_REQ(N), .ISQRT_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_x(req_x), .req_rdy(req_rdy),
        .sq_x_vld(sq_x_vld), .sq_x(sq_x), .sq_y_vld(sq_y_vld), .sq_y(sq_y),
        .rsp_vld(rsp_vld), .rsp_y(rsp_y), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural isqrt: floor(sqrt(x)), LAT cycles from x_vld to y_vld, shares rst.
    function automatic logic [15:0] isqrt(input logic [31:0] x);
        logic [15:0] r;
        logic [15:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (16'd1 << b);
            if (32'(t) * 32'(t) <= x) r = t;
        end
        return r;
    endfunction

    logic        pv [LAT];
    logic [15:0] py [LAT];

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) pv[k] <= 1'b0;
        end else begin
            pv[0] <= sq_x_vld;
            py[0] <= isqrt(sq_x);
            for (int k = 1; k < LAT; k++) begin
                pv[k] <= pv[k-1];
                py[k] <= py[k-1];
            end
        end
    end

    assign sq_y_vld = pv[LAT-1] | spur;
    assign sq_y     = py[LAT-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on each response.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            check("rdy_subset_of_vld", 64'(req_rdy & ~req_vld), 64'd0);
            check("rdy_onehot0", 64'($onehot0(req_rdy)), 64'd1);
            for (int i = 0; i < N; i++) begin
                if (req_vld[i] && req_rdy[i]) begin
                    e.idx = i;
                    e.y   = exp_y[i];
                    e.due = cycle + LAT + 1;
                    sb.push_back(e);
                end
            end
            if (sb.size() > 0 && sb[0].due < cycle) begin
                check("rsp_missing_at", 64'(cycle), 64'(sb[0].due));
                void'(sb.pop_front());
            end
            if (rsp_vld != '0) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_vld), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_onehot", 64'(rsp_vld), 64'd1 << e.idx);
                    check("rsp_y", 64'(rsp_y), 64'(e.y));
                    check("rsp_cycle", 64'(cycle), 64'(e.due));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] x, input logic [15:0] y);
        req_x[32*i +: 32] = x;
        exp_y[i] = y;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    logic [31:0] tx [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'hFFFE_0001, 32'hFFFE_0000};
    logic [15:0] ty [5] = '{16'd0, 16'd1, 16'd65535, 16'd65535, 16'd65534};
    int unsigned t0;

    initial begin
        rst     = 1'b1;
        spur    = 1'b0;
        req_vld = '1;
        req_x   = '0;
        for (int i = 0; i < N; i++) exp_y[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rdy_in_reset", 64'(req_rdy), 64'd0);
        cyc();
        req_vld = '0;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("rst_sq_x_vld", 64'(sq_x_vld), 64'd0);
        check("rst_sq_x", 64'(sq_x), 64'd0);
        check("rst_rsp_vld", 64'(rsp_vld), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        // 1. Single request, latency and busy window
        cyc();
        set_req(0, 32'd144, 16'd12);
        req_vld = 4'b0001;
        @(negedge clk);
        check("t1_grant", 64'(req_rdy), 64'b0001);
        check("t1_busy_T", 64'(busy), 64'd0);
        t0 = cycle;
        cyc();
        req_vld = '0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            check("t1_busy", 64'(busy), (k <= 17) ? 64'd1 : 64'd0);
            if (k == 1) begin
                check("t1_sq_x_vld", 64'(sq_x_vld), 64'd1);
                check("t1_sq_x", 64'(sq_x), 64'd144);
            end
            if (k == 17) check("t1_rsp_at_T17", 64'(rsp_vld), 64'b0001);
        end

        // 2. All four held: grants rotate 0,1,2,3,0,...
        do_reset();
        set_req(0, 32'd16, 16'd4);
        set_req(1, 32'd25, 16'd5);
        set_req(2, 32'd36, 16'd6);
        set_req(3, 32'd49, 16'd7);
        req_vld = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t2_rotate", 64'(req_rdy), 64'd1 << (k % 4));
            if (k < 7) cyc();
        end
        cyc();
        req_vld = '0;
        repeat (20) @(negedge clk);

        // 3. Wrap and skip, then idle holds ptr and sq_x
        cyc();
        set_req(2, 32'd64, 16'd8);
        req_vld = 4'b0100;
        @(negedge clk);
        check("t3_set_ptr3", 64'(req_rdy), 64'b0100);
        cyc();
        set_req(0, 32'd81, 16'd9);
        set_req(2, 32'd100, 16'd10);
        req_vld = 4'b0101;
        @(negedge clk);
        check("t3_wrap_to_0", 64'(req_rdy), 64'b0001);
        cyc();
        @(negedge clk);
        check("t3_skip_to_2", 64'(req_rdy), 64'b0100);
        cyc();
        req_vld = '0;
        @(negedge clk);
        check("t3_idle_rdy", 64'(req_rdy), 64'd0);
        check("t3_sq_x_last", 64'(sq_x), 64'd100);
        check("t3_sq_x_vld_last", 64'(sq_x_vld), 64'd1);
        cyc();
        @(negedge clk);
        check("t3_sq_x_hold", 64'(sq_x), 64'd100);
        check("t3_sq_x_vld_idle", 64'(sq_x_vld), 64'd0);
        cyc();
        set_req(1, 32'd121, 16'd11);
        set_req(3, 32'd169, 16'd13);
        req_vld = 4'b1010;
        @(negedge clk);
        check("t3_ptr_held", 64'(req_rdy), 64'b1000);
        cyc();
        req_vld = '0;
        repeat (20) @(negedge clk);

        // 4. Operand/result boundaries, back to back
        for (int k = 0; k < 5; k++) begin
            cyc();
            set_req(k % 4, tx[k], ty[k]);
            req_vld = 4'(1 << (k % 4));
            @(negedge clk);
            check("t4_grant", 64'(req_rdy), 64'd1 << (k % 4));
        end
        cyc();
        req_vld = '0;
        repeat (20) @(negedge clk);
        check("t4_err_clear", 64'(err), 64'd0);

        // 5. Reset with three operations in flight
        for (int k = 0; k < 3; k++) begin
            cyc();
            set_req(k, 32'(400 + k), 16'd20);
            req_vld = 4'(1 << k);
            @(negedge clk);
            check("t5_accept", 64'(req_rdy), 64'd1 << k);
        end
        cyc();
        req_vld = '0;
        @(negedge clk);
        @(negedge clk);
        check("t5_busy_before_rst", 64'(busy), 64'd1);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("t5_busy_after_rst", 64'(busy), 64'd0);
        check("t5_sq_x_vld_after_rst", 64'(sq_x_vld), 64'd0);
        for (int k = 0; k < 40; k++) begin
            check("t5_no_rsp", 64'(rsp_vld), 64'd0);
            check("t5_err", 64'(err), 64'd0);
            @(negedge clk);
        end
        cyc();
        for (int i = 0; i < N; i++) set_req(i, 32'd9, 16'd3);
        req_vld = 4'b1111;
        @(negedge clk);
        check("t5_grant_from_0", 64'(req_rdy), 64'b0001);
        cyc();
        req_vld = '0;
        repeat (20) @(negedge clk);

        // 6. Spurious sq_y_vld with no tag in flight
        cyc();
        spur = 1'b1;
        @(negedge clk);
        check("t6_rsp_suppressed", 64'(rsp_vld), 64'd0);
        check("t6_err_not_yet", 64'(err), 64'd0);
        cyc();
        spur = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t6_err_sticky", 64'(err), 64'd1);
            check("t6_rsp_quiet", 64'(rsp_vld), 64'd0);
        end
        do_reset();
        @(negedge clk);
        check("t6_err_cleared", 64'(err), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
